// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg: shared state encoding and default widths for the RAM burst controller.
package ram_burst_pkg;
    localparam int DEF_DW = 4;
    localparam int DEF_AW = 2;
    typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, RD_OUT} ram_burst_state_t;
endpackage

// File: rtl/ram_burst_addr_gen.sv
// ram_burst_addr_gen: burst address/remaining-count tracking and command legality check.
// Defining RAM_BURST_CTRL_WRAP_EN lets bursts wrap past DEPTH-1 instead of rejecting them.
module ram_burst_addr_gen
    import ram_burst_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [AW-1:0] i_addr,
    input  logic [AW:0]   i_len,
    output logic [AW-1:0] o_addr,
    output logic          o_last,
    output logic          o_legal
);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(2**AW);
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_rem;
    logic [AW+1:0] w_end;
    logic          w_len_ok;
    always_comb begin
        w_end    = {2'b00, i_addr} + {1'b0, i_len};
        w_len_ok = (i_len != '0) && ({1'b0, i_len} <= DEPTH_W);
`ifdef RAM_BURST_CTRL_WRAP_EN
        o_legal  = w_len_ok;
`else
        o_legal  = w_len_ok && (w_end <= DEPTH_W);
`endif
        o_addr   = r_addr;
        o_last   = (r_rem == (AW+1)'(1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_rem  <= i_len;
        end else if (i_step) begin
            r_addr <= r_addr + AW'(1);
            r_rem  <= r_rem - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst initiator for one RAM port, bridging valid/ready streams to wr/en/addr/din/dout.
// Defining RAM_BURST_CTRL_WRAP_EN (in ram_burst_addr_gen) allows bursts to wrap the address space.
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_write,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [AW:0]   i_cmd_len,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    input  logic          i_rd_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_ram_wr,
    output logic          o_ram_en,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_din,
    input  logic [DW-1:0] i_ram_dout
);
    ram_burst_state_t r_state;
    logic [DW-1:0]    r_rd_data;
    logic             r_rd_valid;
    logic             r_done;
    logic             r_err;
    logic [AW-1:0]    w_addr;
    logic             w_last;
    logic             w_legal;
    logic             w_load;
    logic             w_step;
    logic             w_wr_beat;
    logic             w_rd_issue;
    ram_burst_addr_gen #(.AW(AW)) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_addr  (i_cmd_addr),
        .i_len   (i_cmd_len),
        .o_addr  (w_addr),
        .o_last  (w_last),
        .o_legal (w_legal)
    );
    // RAM strobes are gated by rst so an aborted burst cannot land a write on the reset edge.
    always_comb begin
        w_wr_beat   = (r_state == WR) && i_wr_valid && !rst;
        w_rd_issue  = (r_state == RD_ADDR) && !rst;
        w_load      = (r_state == IDLE) && i_cmd_valid && w_legal && !rst;
        w_step      = w_wr_beat || ((r_state == RD_OUT) && i_rd_ready);
        o_cmd_ready = (r_state == IDLE) && !rst;
        o_wr_ready  = (r_state == WR);
        o_busy      = (r_state != IDLE);
        o_rd_data   = r_rd_data;
        o_rd_valid  = r_rd_valid;
        o_done      = r_done;
        o_err       = r_err;
        o_ram_en    = w_wr_beat || w_rd_issue;
        o_ram_wr    = w_wr_beat;
        o_ram_addr  = (w_wr_beat || w_rd_issue) ? w_addr : '0;
        o_ram_din   = w_wr_beat ? i_wr_data : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        if (w_legal) r_state <= i_cmd_write ? WR : RD_ADDR;
                        else r_err <= 1'b1;
                    end
                end
                WR: begin
                    if (i_wr_valid && w_last) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                RD_ADDR: r_state <= RD_CAP;
                RD_CAP: begin
                    r_rd_data  <= i_ram_dout;
                    r_rd_valid <= 1'b1;
                    r_state    <= RD_OUT;
                end
                RD_OUT: begin
                    if (i_rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_done     <= w_last;
                        r_state    <= w_last ? IDLE : RD_ADDR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed bench for ram_burst_ctrl with a behavioural RAM and write/read scoreboards.
// Covers both RAM_BURST_CTRL_WRAP_EN builds for the out-of-range burst case.
module tb_ram_burst_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [1:0] cmd_addr = '0;
    logic [2:0] cmd_len = '0;
    logic [3:0] wr_data = '0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [3:0] rd_data;
    logic       rd_valid, rd_ready = 1'b0;
    logic       busy, done, err;
    logic       ram_wr, ram_en;
    logic [1:0] ram_addr;
    logic [3:0] ram_din, ram_dout;
    logic [3:0] ram [4];
    logic [3:0] model [4];
    logic [5:0] exp_wq [$];
    logic [3:0] exp_rq [$];
    logic [5:0] we;
    logic [3:0] re;
    int n_assert = 0, n_fail = 0;
    int n_en = 0, n_done = 0, n_err = 0;
    int e0, d0, r0;
    logic [3:0] hold;

    always #5 clk = ~clk;

    ram_burst_ctrl dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_ram_wr(ram_wr), .o_ram_en(ram_en), .o_ram_addr(ram_addr),
        .o_ram_din(ram_din), .i_ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) ram[ram_addr] <= ram_din;
            else ram_dout <= ram[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_en) n_en++;
        if (done) n_done++;
        if (err) n_err++;
        if (ram_en && ram_wr) begin
            chk("wr_expected", 32'(exp_wq.size() != 0), 1);
            if (exp_wq.size() != 0) begin
                we = exp_wq.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(we[5:4]));
                chk("wr_data", 32'(ram_din), 32'(we[3:0]));
            end
        end
        if (rd_valid && rd_ready) begin
            chk("rd_expected", 32'(exp_rq.size() != 0), 1);
            if (exp_rq.size() != 0) begin
                re = exp_rq.pop_front();
                chk("rd_data", 32'(rd_data), 32'(re));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic w, input logic [1:0] a, input logic [2:0] l);
        chk("cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [1:0] a, input logic [2:0] l, input logic [3:0] d);
        logic [1:0] ad;
        logic [3:0] dd;
        int s;
        cmd(1'b1, a, l);
        s = n_en;
        for (int i = 0; i < int'(l); i++) begin
            ad = a + 2'(i);
            dd = d + 4'(i);
            chk("wr_ready", 32'(wr_ready), 1);
            exp_wq.push_back({ad, dd});
            model[ad] = dd;
            wr_valid = 1'b1; wr_data = dd;
            step();
        end
        wr_valid = 1'b0;
        chk("wr_done", 32'(done), 1);
        chk("wr_busy_after", 32'(busy), 0);
        chk("wr_cmd_ready_with_done", 32'(cmd_ready), 1);
        chk("wr_en_count", 32'(n_en - s), 32'(l));
        chk("wr_q_empty", 32'(exp_wq.size()), 0);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 60 && !done; k++) step();
        chk(tag, 32'(done), 1);
        chk("rd_q_empty", 32'(exp_rq.size()), 0);
        rd_ready = 1'b0;
    endtask

    task automatic rd_burst(input logic [1:0] a, input logic [2:0] l);
        cmd(1'b0, a, l);
        for (int i = 0; i < int'(l); i++) exp_rq.push_back(model[a + 2'(i)]);
        rd_ready = 1'b1;
        wait_done("rd_done_seen");
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin ram[i] = '0; model[i] = '0; end
        ram_dout = '0;
        step(); step();
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        rst = 1'b0;
        step();
        // Full-depth write, then read it back with exact first-beat latency.
        wr_burst(2'd0, 3'd4, 4'hA);
        step();
        cmd(1'b0, 2'd0, 3'd4);
        for (int i = 0; i < 4; i++) exp_rq.push_back(model[i]);
        rd_ready = 1'b1;
        chk("rd_t1_valid", 32'(rd_valid), 0);
        chk("rd_t1_ram_en", 32'(ram_en), 1);
        chk("rd_t1_ram_wr", 32'(ram_wr), 0);
        step();
        chk("rd_t2_valid", 32'(rd_valid), 0);
        chk("rd_t2_ram_en", 32'(ram_en), 0);
        step();
        chk("rd_t3_valid", 32'(rd_valid), 1);
        wait_done("rd4_done_seen");
        // Backpressure: held beat must stay stable with no RAM traffic.
        step();
        cmd(1'b0, 2'd1, 3'd2);
        exp_rq.push_back(model[1]);
        exp_rq.push_back(model[2]);
        step(); step();
        chk("bp_valid", 32'(rd_valid), 1);
        chk("bp_first_data", 32'(rd_data), 32'(model[1]));
        hold = rd_data;
        e0 = n_en;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(rd_valid), 1);
            chk("bp_hold_data", 32'(rd_data), 32'(hold));
        end
        chk("bp_no_ram", 32'(n_en - e0), 0);
        rd_ready = 1'b1;
        wait_done("bp_done_seen");
        // Illegal lengths.
        step();
        e0 = n_en; d0 = n_done; r0 = n_err;
        cmd(1'b0, 2'd0, 3'd0);
        chk("len0_err", 32'(err), 1);
        chk("len0_busy", 32'(busy), 0);
        step();
        chk("len0_err_pulse", 32'(err), 0);
        cmd(1'b1, 2'd0, 3'd5);
        chk("len5_err", 32'(err), 1);
        chk("len5_busy", 32'(busy), 0);
        step();
        chk("len5_err_pulse", 32'(err), 0);
        chk("illegal_no_ram", 32'(n_en - e0), 0);
        chk("illegal_no_done", 32'(n_done - d0), 0);
        chk("illegal_err_count", 32'(n_err - r0), 2);
        // Burst running past the top of the address space.
`ifdef RAM_BURST_CTRL_WRAP_EN
        wr_burst(2'd3, 3'd2, 4'h5);
        step();
        rd_burst(2'd3, 3'd2);
`else
        e0 = n_en;
        cmd(1'b1, 2'd3, 3'd2);
        chk("oob_err", 32'(err), 1);
        chk("oob_busy", 32'(busy), 0);
        step();
        chk("oob_no_ram", 32'(n_en - e0), 0);
        wr_burst(2'd2, 3'd2, 4'h5);
`endif
        // Reset after two of four write beats.
        step();
        d0 = n_done;
        cmd(1'b1, 2'd0, 3'd4);
        for (int i = 0; i < 2; i++) begin
            exp_wq.push_back({2'(i), 4'(i + 1)});
            model[i] = 4'(i + 1);
            wr_valid = 1'b1; wr_data = 4'(i + 1);
            step();
        end
        wr_data = 4'h3;
        rst = 1'b1;
        step();
        chk("abort_cmd_ready", 32'(cmd_ready), 0);
        chk("abort_wr_ready", 32'(wr_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ram_en", 32'(ram_en), 0);
        chk("abort_ram_wr", 32'(ram_wr), 0);
        chk("abort_ram_addr", 32'(ram_addr), 0);
        chk("abort_ram_din", 32'(ram_din), 0);
        chk("abort_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        wr_valid = 1'b0;
        step();
        chk("abort_no_done", 32'(n_done - d0), 0);
        rd_burst(2'd0, 3'd4);
        chk("final_wq_empty", 32'(exp_wq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Single-clock burst controller that drives one port of the team's dual-port RAM as its initiator. It accepts a burst command (start address, length, direction), streams write beats from a valid/ready source into the RAM, or streams read beats from the RAM to a valid/ready sink. It sits between a datapath client and the RAM's `wr`/`en`/`address`/`din`/`dout` port, hiding the RAM's one-cycle registered read latency.

## Interface
- `DW`, 4, data width; equals the RAM word width.
- `AW`, 2, address width; DEPTH = 2**AW.

- `clk` in 1: RAM-side clock; all logic is on posedge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` / `cmd_ready` in/out 1: command handshake.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in AW: start address.
- `cmd_len` in AW+1: beat count; legal range 1..DEPTH.
- `wr_data` in DW, `wr_valid` in 1, `wr_ready` out 1: write-beat stream.
- `rd_data` out DW, `rd_valid` out 1, `rd_ready` in 1: read-beat stream.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse after the last beat of an accepted burst.
- `err` out 1: one-cycle pulse when a command is rejected.
- `ram_wr`, `ram_en` out 1; `ram_addr` out AW; `ram_din` out DW; `ram_dout` in DW: RAM port.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_CAP, RD_OUT.
- IDLE: `cmd_ready` = 1. On handshake, latch addr/len. Legal write → WR; legal read → RD_ADDR. Illegal commands are still consumed, pulse `err`, cause no RAM access and no `done`, and the FSM stays in IDLE.
- A command is illegal if `cmd_len` == 0 or `cmd_len` > DEPTH. The range rule under Configuration also applies.
- WR: `wr_ready` = 1. On each `wr_valid`, drive combinationally `ram_en` = 1, `ram_wr` = 1, `ram_addr` = current address, `ram_din` = `wr_data`. Advance the address and decrement the remaining count. The last beat → IDLE.
- RD_ADDR: `ram_en` = 1, `ram_wr` = 0, `ram_addr` = current address → RD_CAP.
- RD_CAP: `ram_wr` = 0 (RAM output holds). Register `rd_data` <= `ram_dout` and set `rd_valid` → RD_OUT.
- RD_OUT: hold `rd_data` and `rd_valid` until `rd_ready`. On handshake, clear `rd_valid`. If beats remain, advance the address → RD_ADDR; otherwise → IDLE.
- Address arithmetic is AW bits and naturally modulo DEPTH. The remaining count is AW+1 bits.
- Outside the states above, `ram_en` = `ram_wr` = 0, and `ram_addr` / `ram_din` = 0.
- `done` is registered: it is high for the cycle after the final write-beat or read-beat handshake.
- Reset values: `cmd_ready` 0 while `rst` is high; `wr_ready` 0; `rd_valid` 0; `rd_data` 0; `busy` 0; `done` 0; `err` 0; all `ram_*` outputs 0.
- Reset mid-burst aborts immediately: no further RAM writes, no `done`, and any pending read beat is dropped.

## Timing
- Command handshake at edge T → first WR beat can be accepted in cycle T+1.
- Write throughput is 1 beat/cycle; the RAM write lands at the edge that ends the beat cycle.
- Read: RD_ADDR in cycle T+1, RD_CAP in T+2, `rd_valid` high from T+3. Minimum read beat spacing is 3 cycles.
- A `rd_ready` held high while `rd_valid` is low has no effect.
- `cmd_ready` is high in the same cycle as `done`, so back-to-back bursts have one idle cycle between their beats.
- `err` is high in cycle T+1 after an illegal-command handshake at edge T.

## Configuration
- `RAM_BURST_CTRL_WRAP_EN` defined: bursts whose addresses run past DEPTH-1 wrap to 0 (e.g. addr 3, len 3 → 3, 0, 1).
- `RAM_BURST_CTRL_WRAP_EN` undefined: a command with `cmd_addr` + `cmd_len` > DEPTH is illegal and is rejected with `err`.

## Structure
- Package `ram_burst_pkg` holds the state enum `ram_burst_state_t` and the default DW/AW constants.
- Sub-module `ram_burst_addr_gen` holds the address register, remaining-count register, last-beat flag and the legality check (including the wrap/bound rule). The top level holds the FSM and the stream registers.

## Test plan
- Write addr 0, len 4, data 0xA, 0xB, 0xC, 0xD with `wr_valid` held high → 4 consecutive `ram_wr` cycles at addresses 0..3, then `done` 1 cycle later.
- Read addr 0, len 4 after the previous write, `rd_ready` high → `rd_data` = 0xA, 0xB, 0xC, 0xD, first `rd_valid` 3 cycles after the handshake, then `done`.
- Read len 2 with `rd_ready` held low for 5 cycles → `rd_valid` and `rd_data` stable, no RAM access until release.
- `cmd_len` = 0 and `cmd_len` = 5 → `err` pulse each time, no `ram_en`, `busy` stays 0.
- Addr 3, len 2 → with WRAP_EN, addresses 3 then 0; without WRAP_EN, `err` and no access.
- `rst` asserted after 2 of 4 write beats → all outputs take their reset values next cycle, no `done`, memory words 2 and 3 unchanged.
